// File: rtl/core_mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : core_mem_port_arbiter_pkg
// Brief   : Shared types and constants for the core memory-port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package core_mem_port_arbiter_pkg;

  // Default number of memory clients per core (icache + load/store unit).
  localparam int MEM_REQ_PER_CORE = 2;

  // Arbitration policy selectors.
  localparam int ARB_MODE_FIXED = 0;
  localparam int ARB_MODE_RR    = 1;

  // Channel index reserved for the instruction cache.
  localparam int ICACHE_CH_ID = 0;

  // Field widths of a memory request / response beat.
  localparam int ACCESS_ID_W = 16;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;

  // Request / response beat shared by clients, the memory port and responses.
  typedef struct packed {
    logic                   vld;
    logic                   we;
    logic [ACCESS_ID_W-1:0] access_id;
    logic [ADDR_W-1:0]      addr;
    logic [DATA_W-1:0]      data;
  } request_t;

endpackage : core_mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/core_mem_port_arbiter_rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module  : rr_priority_picker
// Brief   : Combinational rotating-priority picker. Searches the eligible
//           vector upward from i_ptr with wrap-around and returns a one-hot
//           grant plus the binary index of the winner. A pointer of 0 turns
//           it into a plain lowest-index-first priority encoder.
// Revision: 1.0 - initial release
// ============================================================================
module rr_priority_picker #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  i_elig,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_shift;
  logic [N-1:0]   w_rot;
  int             w_off;
  int             w_sum;

  // Rotate so the pointer position lands at bit 0, pick the lowest set bit,
  // then map the offset back to an absolute channel index.
  always_comb begin
    w_dbl   = {i_elig, i_elig};
    w_shift = w_dbl >> i_ptr;
    w_rot   = w_shift[N-1:0];
    o_any   = |w_rot;
    w_off   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = k;
      end
    end
    w_sum = int'(i_ptr) + w_off;
    if (w_sum >= N) begin
      w_sum = w_sum - N;
    end
    o_idx = o_any ? PW'(w_sum) : '0;
    for (int i = 0; i < N; i++) begin
      o_grant[i] = o_any && (w_sum == i);
    end
  end

endmodule : rr_priority_picker
`default_nettype wire

// File: rtl/core_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : core_mem_port_arbiter
// Brief   : Arbitrates NUM_REQ memory clients onto the single core memory
//           port (fixed or round-robin), honours memory back-pressure, caps
//           in-flight requests per client and routes responses back to the
//           issuing client by the channel field of access_id.
// Revision: 1.0 - initial release
// ============================================================================
module core_mem_port_arbiter
  import core_mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = MEM_REQ_PER_CORE,
  parameter int ARB_MODE  = ARB_MODE_FIXED,
  parameter int CH_LSB    = 6,
  parameter int CH_BITS   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  parameter int MAX_OUTST = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  request_t           req_in     [NUM_REQ],
  output logic [NUM_REQ-1:0] req_grant,
  input  logic               mem_busy,
  output request_t           mem_req,
  input  request_t           mem_rsp,
  output request_t           rsp_out    [NUM_REQ],
  output logic [NUM_REQ-1:0] outst_full,
  output logic               rsp_err
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int PW = $clog2(NUM_REQ);

  // Request side
  logic [NUM_REQ-1:0] w_vld;
  logic [NUM_REQ-1:0] w_full;
  logic [NUM_REQ-1:0] w_elig;
  logic [PW-1:0]      w_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic [PW-1:0]      w_idx;
  logic               w_any;
  request_t           w_sel;

  // Response side
  logic [CH_BITS-1:0] w_rsp_ch;
  logic               w_rsp_ch_ok;
  logic [NUM_REQ-1:0] w_rsp_hit;
  logic [NUM_REQ-1:0] w_cnt_zero;
  logic               w_err_evt;

  // State
  logic [CW-1:0]      r_cnt     [NUM_REQ];
  request_t           r_rsp_out [NUM_REQ];
  logic [PW-1:0]      r_rr_ptr;
  request_t           r_mem_req;
  logic               r_rsp_err;

  // Response channel decode; out-of-range channels are treated as errors.
  assign w_rsp_ch    = mem_rsp.access_id[CH_LSB +: CH_BITS];
  assign w_rsp_ch_ok = (int'(w_rsp_ch) < NUM_REQ);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ch
    assign w_vld[i]      = req_in[i].vld;
    assign w_full[i]     = (r_cnt[i] == CW'(MAX_OUTST));
    assign w_cnt_zero[i] = (r_cnt[i] == '0);
    assign w_rsp_hit[i]  = mem_rsp.vld && w_rsp_ch_ok && (int'(w_rsp_ch) == i);

    // In-flight counter: +1 on grant, -1 on a routed response; a response to
    // an empty counter is delivered but must not underflow it.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt[i] <= '0;
      end else if (w_grant[i] && !(w_rsp_hit[i] && !w_cnt_zero[i])) begin
        r_cnt[i] <= r_cnt[i] + CW'(1);
      end else if (!w_grant[i] && w_rsp_hit[i] && !w_cnt_zero[i]) begin
        r_cnt[i] <= r_cnt[i] - CW'(1);
      end
    end

    // Per-client response register: a beat lasts exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_rsp_out[i] <= '0;
      end else begin
        r_rsp_out[i] <= w_rsp_hit[i] ? mem_rsp : '0;
      end
    end

    assign rsp_out[i] = r_rsp_out[i];
  end

  // A channel competes only when it has a request, headroom and the port is free.
  assign w_elig = w_vld & ~w_full & {NUM_REQ{~mem_busy}};

  // Fixed priority is the rotating search anchored at channel 0.
  assign w_ptr = (ARB_MODE == ARB_MODE_RR) ? r_rr_ptr : '0;

  rr_priority_picker #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_picker (
    .i_elig  (w_elig),
    .i_ptr   (w_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Select the payload of the granted client (grant is one-hot).
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel = req_in[i];
      end
    end
  end

  // Memory request register: load on grant, clear when idle, hold while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_req <= '0;
    end else if (w_any) begin
      r_mem_req <= w_sel;
    end else if (!mem_busy) begin
      r_mem_req <= '0;
    end
  end

  // Round-robin pointer advances past the winner; stays put without a grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_any) begin
      r_rr_ptr <= (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + PW'(1);
    end
  end

  // Bad channel or response without a matching in-flight request.
  assign w_err_evt = mem_rsp.vld && (!w_rsp_ch_ok || |(w_rsp_hit & w_cnt_zero));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_err <= 1'b0;
    end else if (w_err_evt) begin
      r_rsp_err <= 1'b1;
    end
  end

  assign req_grant  = w_grant;
  assign mem_req    = r_mem_req;
  assign outst_full = w_full;
  assign rsp_err    = r_rsp_err;

endmodule : core_mem_port_arbiter
`default_nettype wire

// File: tb/tb_core_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_core_mem_port_arbiter
// Brief   : Self-checking bench. Two arbiters share one stimulus stream:
//           A = 3 clients, fixed priority, CH_BITS=2 (channel 3 invalid),
//           B = 4 clients, round-robin. Both have MAX_OUTST=2.
// Revision: 1.0 - initial release
// ============================================================================
module tb_core_mem_port_arbiter;
  import core_mem_port_arbiter_pkg::*;

  localparam int M_MAX = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_busy;
  request_t   req     [4];
  request_t   req_a   [3];
  request_t   mem_rsp;
  logic [2:0] grant_a;
  logic [3:0] grant_b;
  request_t   mreq_a;
  request_t   mreq_b;
  request_t   rsp_a   [3];
  request_t   rsp_b   [4];
  logic [2:0] full_a;
  logic [3:0] full_b;
  logic       err_a;
  logic       err_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, index 0 = DUT A, 1 = DUT B
  int       m_cnt  [2][4];
  int       m_ptr  [2];
  request_t m_mreq [2];
  request_t m_rsp  [2][4];
  logic     m_err  [2];

  always #5 clk = ~clk;

  assign req_a[0] = req[0];
  assign req_a[1] = req[1];
  assign req_a[2] = req[2];

  core_mem_port_arbiter #(
    .NUM_REQ(3), .ARB_MODE(ARB_MODE_FIXED), .CH_LSB(6), .CH_BITS(2), .MAX_OUTST(M_MAX)
  ) u_dut_a (
    .clk(clk), .reset(reset), .req_in(req_a), .req_grant(grant_a), .mem_busy(mem_busy),
    .mem_req(mreq_a), .mem_rsp(mem_rsp), .rsp_out(rsp_a), .outst_full(full_a), .rsp_err(err_a)
  );

  core_mem_port_arbiter #(
    .NUM_REQ(4), .ARB_MODE(ARB_MODE_RR), .CH_LSB(6), .MAX_OUTST(M_MAX)
  ) u_dut_b (
    .clk(clk), .reset(reset), .req_in(req), .req_grant(grant_b), .mem_busy(mem_busy),
    .mem_req(mreq_b), .mem_rsp(mem_rsp), .rsp_out(rsp_b), .outst_full(full_b), .rsp_err(err_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int n_of(input int d);
    return (d == 0) ? 3 : 4;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d]  = 0;
      m_mreq[d] = '0;
      m_err[d]  = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_cnt[d][i] = 0;
        m_rsp[d][i] = '0;
      end
    end
  endtask

  // Winner per the policy rules: first eligible channel in search order.
  function automatic int m_grant(input int d);
    int n;
    int j;
    n = n_of(d);
    if (mem_busy) return -1;
    for (int k = 0; k < n; k++) begin
      j = (d == 0) ? k : (m_ptr[d] + k) % n;
      if (req[j].vld && m_cnt[d][j] < M_MAX) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] gvec(input int g);
    return (g < 0) ? 4'b0000 : 4'(1 << g);
  endfunction

  function automatic logic [3:0] fullvec(input int d);
    logic [3:0] v;
    v = '0;
    for (int i = 0; i < n_of(d); i++) v[i] = (m_cnt[d][i] == M_MAX);
    return v;
  endfunction

  task automatic model_step(input int d, input int g);
    int n;
    int ch;
    int pre [4];
    n = n_of(d);
    for (int i = 0; i < 4; i++) pre[i] = m_cnt[d][i];
    if (g >= 0) begin
      m_mreq[d] = req[g];
      m_cnt[d][g]++;
      m_ptr[d] = (g + 1) % n;
    end else if (!mem_busy) begin
      m_mreq[d] = '0;
    end
    for (int i = 0; i < 4; i++) m_rsp[d][i] = '0;
    if (mem_rsp.vld) begin
      ch = int'(mem_rsp.access_id[7:6]);
      if (ch >= n) begin
        m_err[d] = 1'b1;
      end else begin
        m_rsp[d][ch] = mem_rsp;
        if (pre[ch] == 0) m_err[d] = 1'b1;
        else m_cnt[d][ch]--;
      end
    end
  endtask

  task automatic set_req(input int i, input logic v);
    req[i].vld       = v;
    req[i].we        = 1'($urandom_range(0, 1));
    req[i].access_id = {8'($urandom), 2'(i), 6'($urandom)};
    req[i].addr      = $urandom;
    req[i].data      = $urandom;
  endtask

  task automatic set_all(input logic v);
    for (int i = 0; i < 4; i++) set_req(i, v);
  endtask

  task automatic set_rsp(input logic v, input int ch);
    mem_rsp.vld       = v;
    mem_rsp.we        = 1'($urandom_range(0, 1));
    mem_rsp.access_id = {8'($urandom), 2'(ch), 6'($urandom)};
    mem_rsp.addr      = $urandom;
    mem_rsp.data      = $urandom;
  endtask

  // One clock: check combinational outputs, advance the model, check registers.
  task automatic cycle();
    int g [2];
    int ch;
    if (reset) m_reset();
    g[0] = m_grant(0);
    g[1] = m_grant(1);
    // Avoid a response to an empty counter racing a grant on the same channel.
    if (mem_rsp.vld) begin
      ch = int'(mem_rsp.access_id[7:6]);
      for (int d = 0; d < 2; d++)
        if (ch < n_of(d) && g[d] == ch && m_cnt[d][ch] == 0) mem_rsp.vld = 1'b0;
    end
    #1;
    chk("grant_a", 128'(grant_a), 128'(gvec(g[0])));
    chk("grant_b", 128'(grant_b), 128'(gvec(g[1])));
    chk("full_a", 128'(full_a), 128'(fullvec(0)));
    chk("full_b", 128'(full_b), 128'(fullvec(1)));
    if (!reset) begin
      model_step(0, g[0]);
      model_step(1, g[1]);
    end
    @(posedge clk);
    #1;
    chk("mem_req_a", 128'(mreq_a), 128'(m_mreq[0]));
    chk("mem_req_b", 128'(mreq_b), 128'(m_mreq[1]));
    chk("rsp_err_a", 128'(err_a), 128'(m_err[0]));
    chk("rsp_err_b", 128'(err_b), 128'(m_err[1]));
    for (int i = 0; i < 3; i++) chk($sformatf("rsp_a[%0d]", i), 128'(rsp_a[i]), 128'(m_rsp[0][i]));
    for (int i = 0; i < 4; i++) chk($sformatf("rsp_b[%0d]", i), 128'(rsp_b[i]), 128'(m_rsp[1][i]));
  endtask

  initial begin
    logic [3:0] ea [5];
    logic [3:0] eb [5];
    ea = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100};
    eb = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset
    reset    = 1'b1;
    mem_busy = 1'b0;
    set_all(1'b0);
    set_rsp(1'b0, 0);
    m_reset();
    cycle();
    cycle();
    reset = 1'b0;

    // All clients valid: A fixed + per-channel cap, B rotates 0,1,2,3,0
    for (int t = 0; t < 5; t++) begin
      set_all(1'b1);
      #1;
      chk("p1_grant_a", 128'(grant_a), 128'(ea[t]));
      chk("p1_grant_b", 128'(grant_b), 128'(eb[t]));
      cycle();
    end

    // Back-pressure with only client 1 requesting
    set_all(1'b0);
    set_req(1, 1'b1);
    mem_busy = 1'b1;
    for (int t = 0; t < 2; t++) begin
      #1;
      chk("busy_grant_a", 128'(grant_a), 128'(0));
      chk("busy_grant_b", 128'(grant_b), 128'(0));
      cycle();
    end
    mem_busy = 1'b0;
    cycle();

    // Response on channel 3: invalid for A, valid outstanding for B
    set_all(1'b0);
    set_rsp(1'b1, 3);
    cycle();
    set_rsp(1'b0, 0);
    chk("bad_ch_err_a", 128'(err_a), 128'(1));
    chk("bad_ch_err_b", 128'(err_b), 128'(0));

    // Drain remaining outstanding requests
    for (int k = 0; k < 5; k++) begin
      set_rsp(1'b1, (k < 2) ? 0 : (k < 4) ? 1 : 2);
      cycle();
    end
    set_rsp(1'b0, 0);
    cycle();
    chk("drain_full_a", 128'(full_a), 128'(0));
    chk("drain_full_b", 128'(full_b), 128'(0));
    chk("err_sticky_a", 128'(err_a), 128'(1));
    chk("drain_err_b", 128'(err_b), 128'(0));

    // Channel 0 hits its cap, then a response reopens it
    set_req(0, 1'b1);
    cycle();
    set_req(0, 1'b1);
    cycle();
    set_req(0, 1'b1);
    #1;
    chk("cap_full_a0", 128'(full_a[0]), 128'(1));
    chk("cap_grant_a", 128'(grant_a), 128'(0));
    cycle();
    set_rsp(1'b1, 0);
    cycle();
    set_rsp(1'b0, 0);
    #1;
    chk("reopen_rsp_a0", 128'(rsp_a[0].vld), 128'(1));
    chk("reopen_grant_a", 128'(grant_a), 128'(1));
    cycle();

    // Asynchronous reset in the middle of traffic
    set_all(1'b1);
    cycle();
    set_all(1'b1);
    cycle();
    reset = 1'b1;
    #1;
    chk("arst_mreq_a", 128'(mreq_a), 128'(0));
    chk("arst_mreq_b", 128'(mreq_b), 128'(0));
    chk("arst_full_a", 128'(full_a), 128'(0));
    chk("arst_full_b", 128'(full_b), 128'(0));
    chk("arst_err_a", 128'(err_a), 128'(0));
    chk("arst_rsp_b0", 128'(rsp_b[0]), 128'(0));
    m_reset();
    cycle();
    reset = 1'b0;
    set_all(1'b1);
    #1;
    chk("post_rst_grant_a", 128'(grant_a), 128'(1));
    chk("post_rst_grant_b", 128'(grant_b), 128'(1));
    cycle();

    // Randomised traffic with periodic reset pulses
    for (int t = 0; t < 400; t++) begin
      reset    = (t % 80 == 40);
      mem_busy = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < 4; i++) set_req(i, $urandom_range(0, 9) < 6);
      set_rsp($urandom_range(0, 9) < 4, int'($urandom_range(0, 3)));
      cycle();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_core_mem_port_arbiter
`default_nettype wire

// File: doc/core_mem_port_arbiter.md
# core_mem_port_arbiter

Parametrised memory-port arbiter and response router between a core's memory clients and its single memory port. It generalises the fixed two-client icache/load-store selection to NUM_REQ clients. It adds a selectable fixed-priority or round-robin policy, memory back-pressure, per-client outstanding-request limits and response routing by an access_id channel field. It sits at core top level, between the client `request_t` ports and the core `mem_req`/`mem_rsp` pins.

## Interface
- NUM_REQ, 2, number of client channels (2..8); channel 0 is the icache.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- CH_LSB, 6, lowest bit of the channel field in `access_id`.
- CH_BITS, $clog2(NUM_REQ), width of the channel field; minimum 1.
- MAX_OUTST, 16, maximum in-flight requests per channel.
- clk  input  1  core clock.
- reset  input  1  asynchronous reset, active-high.
- req_in  input  request_t [NUM_REQ]  client requests, qualified by `.vld`.
- req_grant  output  [NUM_REQ]  one-hot combinational grant.
- mem_busy  input  1  memory port cannot accept a request this cycle.
- mem_req  output  request_t  registered request to memory.
- mem_rsp  input  request_t  response from memory, qualified by `.vld`.
- rsp_out  output  request_t [NUM_REQ]  registered per-client responses.
- outst_full  output  [NUM_REQ]  channel is at MAX_OUTST.
- rsp_err  output  1  sticky error flag.

## Operation
- Eligibility: channel i is eligible when `req_in[i].vld`, `!outst_full[i]` and `!mem_busy`.
- Arbitration:
  - Fixed mode grants the lowest eligible index.
  - Round-robin mode searches from `rr_ptr` upward with wrap. On each grant, `rr_ptr` moves to (granted index + 1) mod NUM_REQ. `rr_ptr` does not move when nothing is granted.
- Grant handshake: `req_grant` is at most one-hot. A client holds `vld` and its payload until granted. It may deassert `vld` only in the cycle after grant, or present its next request then.
- Request path:
  - On a grant, `mem_req` ← `req_in[g]` at the next edge.
  - If there is no grant and `!mem_busy`, `mem_req` ← 0.
  - While `mem_busy`, `mem_req` holds its value.
- Outstanding counters: per channel, $clog2(MAX_OUTST+1) bits.
  - Increment on grant.
  - Decrement on a valid response routed to that channel.
  - Grant and response on the same channel in the same cycle leave the counter unchanged.
  - `outst_full[i]` = (count == MAX_OUTST).
- Response routing: ch = `mem_rsp.access_id[CH_LSB +: CH_BITS]`. On `mem_rsp.vld` with ch < NUM_REQ, `rsp_out[ch]` ← `mem_rsp` and every other `rsp_out` ← 0. Without `vld`, all `rsp_out` ← 0.
- Errors:
  - A response with ch ≥ NUM_REQ is dropped, all `rsp_out` ← 0, and `rsp_err` sets.
  - A response to a channel whose count is 0 is delivered, the counter stays at 0, and `rsp_err` sets.
  - `rsp_err` clears only on reset.

## Timing
- Reset values: `mem_req` = 0, `rsp_out` = 0, `rsp_err` = 0, all counters = 0, `rr_ptr` = 0, hence `outst_full` = 0.
- `req_grant` is combinational: it depends on `req_in[*].vld`, `mem_busy`, the counters and `rr_ptr`.
- Request latency is 1 cycle, from the grant-cycle edge to `mem_req` valid.
- Response latency is 1 cycle, from `mem_rsp` to `rsp_out`.
- Back-to-back grants to the same or different channels are allowed every cycle while `!mem_busy`.
- A `mem_busy` rising edge blocks grants in that same cycle. The `mem_req` registered in the previous cycle stays stable until `mem_busy` falls.
- Reset asserted mid-operation clears all in-flight state immediately. In-flight responses that arrive after reset releases set `rsp_err`.

## Structure
- Shared package: `request_t`, `MEM_REQ_PER_CORE` (as the NUM_REQ default), the `ARB_MODE_FIXED`/`ARB_MODE_RR` constants, and `ICACHE_CH_ID`.
- Sub-module `rr_priority_picker`: combinational, takes an eligible vector and a pointer, returns a one-hot grant and an index. Fixed mode drives it with a pointer of 0.
- The top holds the output registers, the counters, `rr_ptr` and the router.

## Test plan
- Fixed mode, NUM_REQ=2: both clients are valid for 3 cycles. Required: `req_grant` = 01 all three cycles, and `mem_req` equals client 0's payload from cycle 1.
- Round-robin, NUM_REQ=4, all clients valid continuously: grants cycle 0,1,2,3,0. `mem_req` access_ids match with a 1-cycle lag.
- `mem_busy` held 2 cycles while client 1 is valid: `req_grant` = 0 and `mem_req` is held. The grant occurs in the cycle after `mem_busy` falls.
- MAX_OUTST=2 with no responses:
  - Two grants to channel 0, then `outst_full[0]` = 1 and channel 0 gets no further grant.
  - Send a response with `access_id[6]` = 0: `rsp_out[0]` is valid 1 cycle later, `outst_full[0]` = 0, and a new grant follows.
- Response with access_id channel 3 at NUM_REQ=2 (CH_BITS=2): all `rsp_out` = 0 and `rsp_err` = 1, and it stays 1 until reset.
- Assert reset with counters at 1 and `mem_req` valid: all outputs and counters read 0 in the same cycle. After reset releases, normal arbitration resumes from `rr_ptr` = 0.
